// File: rtl/warp_dvg_ctrl.sv
// Per-warp divergence state: thread mask, PC and join-pending bit per warp.
// Split results and join responses rewrite the mask/PC, and the pending
// bits stall a warp between join issue and join response.

`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

module warp_dvg_ctrl #(
    parameter int               THREAD_CNT     = `NUM_THREADS,
    parameter int               WARP_CNT       = `NUM_WARPS,
    parameter int               WARP_CNT_WIDTH = `NW_WIDTH,
    parameter logic [`XLEN-1:0] STARTUP_ADDR   = `XLEN'h80000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      split_valid,
    input  logic [WARP_CNT_WIDTH-1:0] split_wid,
    input  logic                      split_is_dvg,
    input  logic [THREAD_CNT-1:0]     split_then_tmask,
    input  logic [THREAD_CNT-1:0]     split_else_tmask,
    input  logic                      join_issue_valid,
    input  logic [WARP_CNT_WIDTH-1:0] join_issue_wid,
    input  logic                      join_valid,
    input  logic                      join_is_dvg,
    input  logic                      join_is_else,
    input  logic [WARP_CNT_WIDTH-1:0] join_wid,
    input  logic [THREAD_CNT-1:0]     join_tmask,
    input  logic [`XLEN-1:0]          join_pc,
    input  logic                      pc_upd_valid,
    input  logic [WARP_CNT_WIDTH-1:0] pc_upd_wid,
    input  logic [`XLEN-1:0]          pc_upd_pc,
    input  logic [WARP_CNT_WIDTH-1:0] rd_wid,
    output logic [THREAD_CNT-1:0]     rd_tmask,
    output logic [`XLEN-1:0]          rd_pc,
    output logic [WARP_CNT-1:0]       join_stalled,
    output logic                      proto_err
);

    // Architectural state and its next value
    logic [THREAD_CNT-1:0] tmask_p0  [WARP_CNT];
    logic [`XLEN-1:0]      pc_p0     [WARP_CNT];
    logic [WARP_CNT-1:0]   pend_p0;
    logic                  err_p0;

    logic [THREAD_CNT-1:0] tmask_nxt [WARP_CNT];
    logic [`XLEN-1:0]      pc_nxt    [WARP_CNT];
    logic [WARP_CNT-1:0]   pend_nxt;
    logic                  err_nxt;

    // A warp id is usable only if it names an existing warp
    function automatic logic wid_ok(input logic [WARP_CNT_WIDTH-1:0] w);
        return (32'(w) < 32'(WARP_CNT));
    endfunction

    // Non-divergent split: whichever path has live threads takes the whole warp
    function automatic logic [THREAD_CNT-1:0] split_mask(
        input logic                  is_dvg,
        input logic [THREAD_CNT-1:0] then_m,
        input logic [THREAD_CNT-1:0] else_m
    );
        if (is_dvg || (then_m != '0)) return then_m;
        return else_m;
    endfunction

    // Next-state: updates applied lowest priority first so later writes win
    always_comb begin
        tmask_nxt = tmask_p0;
        pc_nxt    = pc_p0;
        pend_nxt  = pend_p0;
        err_nxt   = err_p0;

        if (pc_upd_valid) begin
            if (wid_ok(pc_upd_wid)) pc_nxt[pc_upd_wid] = pc_upd_pc;
            else                    err_nxt = 1'b1;
        end

        if (split_valid) begin
            if (wid_ok(split_wid)) begin
                tmask_nxt[split_wid] = split_mask(split_is_dvg, split_then_tmask,
                                                  split_else_tmask);
                if (pend_p0[split_wid] || (join_valid && (join_wid == split_wid)))
                    err_nxt = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
        end

        if (join_valid) begin
            if (wid_ok(join_wid)) begin
                if (!pend_p0[join_wid]) err_nxt = 1'b1;
                pend_nxt[join_wid] = 1'b0;
                if (join_is_dvg) tmask_nxt[join_wid] = join_tmask;
                if (join_is_dvg && join_is_else) pc_nxt[join_wid] = join_pc;
            end else begin
                err_nxt = 1'b1;
            end
        end

        // Issue follows the response so a same-warp pair leaves pending set
        if (join_issue_valid) begin
            if (wid_ok(join_issue_wid)) begin
                if (pend_nxt[join_issue_wid]) err_nxt = 1'b1;
                pend_nxt[join_issue_wid] = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    // ---- stage p0: state registers ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WARP_CNT; i++) begin
                tmask_p0[i] <= (i == 0) ? THREAD_CNT'(1) : '0;
                pc_p0[i]    <= STARTUP_ADDR;
            end
            pend_p0 <= '0;
            err_p0  <= 1'b0;
        end else begin
            tmask_p0 <= tmask_nxt;
            pc_p0    <= pc_nxt;
            pend_p0  <= pend_nxt;
            err_p0   <= err_nxt;
        end
    end

    // Combinational read port over current register contents
    always_comb begin
        rd_tmask = '0;
        rd_pc    = '0;
        if (wid_ok(rd_wid)) begin
            rd_tmask = tmask_p0[rd_wid];
            rd_pc    = pc_p0[rd_wid];
        end
    end

    assign join_stalled = pend_p0;
    assign proto_err    = err_p0;

endmodule

// File: tb/tb_warp_dvg_ctrl.sv
// Directed bench for warp_dvg_ctrl with a scoreboard of expected warp state.
module tb_warp_dvg_ctrl;

    localparam logic [31:0] B = 32'h80000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        split_valid = 1'b0;
    logic [1:0]  split_wid = '0;
    logic        split_is_dvg = 1'b0;
    logic [3:0]  split_then_tmask = '0;
    logic [3:0]  split_else_tmask = '0;
    logic        join_issue_valid = 1'b0;
    logic [1:0]  join_issue_wid = '0;
    logic        join_valid = 1'b0;
    logic        join_is_dvg = 1'b0;
    logic        join_is_else = 1'b0;
    logic [1:0]  join_wid = '0;
    logic [3:0]  join_tmask = '0;
    logic [31:0] join_pc = '0;
    logic        pc_upd_valid = 1'b0;
    logic [1:0]  pc_upd_wid = '0;
    logic [31:0] pc_upd_pc = '0;
    logic [1:0]  rd_wid = '0;
    logic [3:0]  rd_tmask;
    logic [31:0] rd_pc;
    logic [3:0]  join_stalled;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [1:0]  wid;
        logic [3:0]  tm;
        logic [31:0] pc;
        logic [3:0]  st;
        logic        er;
    } exp_t;
    exp_t sb[$];

    warp_dvg_ctrl #(
        .THREAD_CNT(4), .WARP_CNT(4), .WARP_CNT_WIDTH(2), .STARTUP_ADDR(B)
    ) dut (
        .clk(clk), .reset(reset),
        .split_valid(split_valid), .split_wid(split_wid), .split_is_dvg(split_is_dvg),
        .split_then_tmask(split_then_tmask), .split_else_tmask(split_else_tmask),
        .join_issue_valid(join_issue_valid), .join_issue_wid(join_issue_wid),
        .join_valid(join_valid), .join_is_dvg(join_is_dvg), .join_is_else(join_is_else),
        .join_wid(join_wid), .join_tmask(join_tmask), .join_pc(join_pc),
        .pc_upd_valid(pc_upd_valid), .pc_upd_wid(pc_upd_wid), .pc_upd_pc(pc_upd_pc),
        .rd_wid(rd_wid), .rd_tmask(rd_tmask), .rd_pc(rd_pc),
        .join_stalled(join_stalled), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_state(input string tag, input logic [1:0] wid, input logic [3:0] tm,
                                input logic [31:0] pc, input logic [3:0] st, input logic er);
        exp_t e;
        e.tag = tag; e.wid = wid; e.tm = tm; e.pc = pc; e.st = st; e.er = er;
        sb.push_back(e);
    endtask

    // Apply inputs across one rising edge, then return all strobes to idle
    task automatic tick();
        @(posedge clk);
        #1;
        split_valid = 1'b0;
        join_issue_valid = 1'b0;
        join_valid = 1'b0;
        pc_upd_valid = 1'b0;
    endtask

    // Pop every queued expectation and compare against the read port and flags
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_wid = e.wid;
            #1;
            checks++;
            assert (rd_tmask === e.tm) else begin
                errors++;
                $error("FAIL %s tmask w%0d: got %h expected %h", e.tag, e.wid, rd_tmask, e.tm);
            end
            checks++;
            assert (rd_pc === e.pc) else begin
                errors++;
                $error("FAIL %s pc w%0d: got %h expected %h", e.tag, e.wid, rd_pc, e.pc);
            end
            checks++;
            assert (join_stalled === e.st) else begin
                errors++;
                $error("FAIL %s join_stalled: got %b expected %b", e.tag, join_stalled, e.st);
            end
            checks++;
            assert (proto_err === e.er) else begin
                errors++;
                $error("FAIL %s proto_err: got %b expected %b", e.tag, proto_err, e.er);
            end
        end
    endtask

    initial begin
        // Reset held two cycles
        tick(); tick();
        reset = 1'b1;
        expect_state("reset_w0", 2'd0, 4'h1, B, 4'h0, 1'b0);
        expect_state("reset_w1", 2'd1, 4'h0, B, 4'h0, 1'b0);
        drain();

        // Non-divergent split with empty then-path takes the else mask
        split_valid = 1; split_wid = 2; split_is_dvg = 0;
        split_then_tmask = 4'h0; split_else_tmask = 4'hF;
        tick();
        expect_state("nodvg_split", 2'd2, 4'hF, B, 4'h0, 1'b0);
        drain();

        // Divergent split installs the then mask
        split_valid = 1; split_wid = 2; split_is_dvg = 1;
        split_then_tmask = 4'h3; split_else_tmask = 4'hC;
        tick();
        expect_state("dvg_split", 2'd2, 4'h3, B, 4'h0, 1'b0);
        drain();

        // Join issue stalls the warp from the next cycle
        join_issue_valid = 1; join_issue_wid = 2;
        tick();
        expect_state("issue_stall", 2'd2, 4'h3, B, 4'h4, 1'b0);
        drain();

        // Else-path response restores mask and PC
        join_valid = 1; join_wid = 2; join_is_dvg = 1; join_is_else = 1;
        join_tmask = 4'hC; join_pc = 32'h80000100;
        tick();
        expect_state("else_join", 2'd2, 4'hC, 32'h80000100, 4'h0, 1'b0);
        drain();

        // Scheduler advances the PC
        pc_upd_valid = 1; pc_upd_wid = 2; pc_upd_pc = 32'h80000104;
        tick();
        expect_state("pc_upd", 2'd2, 4'hC, 32'h80000104, 4'h0, 1'b0);
        drain();

        // Reconvergence keeps the PC
        join_issue_valid = 1; join_issue_wid = 2;
        tick();
        join_valid = 1; join_wid = 2; join_is_dvg = 1; join_is_else = 0;
        join_tmask = 4'hF; join_pc = 32'h0000DEAD;
        tick();
        expect_state("reconverge", 2'd2, 4'hF, 32'h80000104, 4'h0, 1'b0);
        drain();

        // Non-divergent response only clears the stall
        join_issue_valid = 1; join_issue_wid = 2;
        tick();
        join_valid = 1; join_wid = 2; join_is_dvg = 0; join_is_else = 1;
        join_tmask = 4'h1; join_pc = 32'h00000999;
        tick();
        expect_state("nodvg_join", 2'd2, 4'hF, 32'h80000104, 4'h0, 1'b0);
        drain();

        // Response and new issue for the same warp in one cycle leave it pending
        join_issue_valid = 1; join_issue_wid = 0;
        tick();
        join_valid = 1; join_wid = 0; join_is_dvg = 0; join_is_else = 0;
        join_issue_valid = 1; join_issue_wid = 0;
        tick();
        expect_state("resp_issue", 2'd0, 4'h1, B, 4'h1, 1'b0);
        drain();
        join_valid = 1; join_wid = 0; join_is_dvg = 0;
        tick();
        expect_state("resp_clear", 2'd0, 4'h1, B, 4'h0, 1'b0);
        drain();

        // Split and PC update on different warps in one cycle
        split_valid = 1; split_wid = 0; split_is_dvg = 0;
        split_then_tmask = 4'h5; split_else_tmask = 4'hA;
        pc_upd_valid = 1; pc_upd_wid = 3; pc_upd_pc = 32'h80000040;
        tick();
        expect_state("multi_w0", 2'd0, 4'h5, B, 4'h0, 1'b0);
        expect_state("multi_w3", 2'd3, 4'h0, 32'h80000040, 4'h0, 1'b0);
        drain();

        // Collision on warp 1: response beats split and PC update
        join_issue_valid = 1; join_issue_wid = 1;
        tick();
        join_valid = 1; join_wid = 1; join_is_dvg = 1; join_is_else = 1;
        join_tmask = 4'h6; join_pc = 32'h00000200;
        pc_upd_valid = 1; pc_upd_wid = 1; pc_upd_pc = 32'h00000300;
        split_valid = 1; split_wid = 1; split_is_dvg = 1;
        split_then_tmask = 4'h9; split_else_tmask = 4'h6;
        tick();
        expect_state("collision", 2'd1, 4'h6, 32'h00000200, 4'h0, 1'b1);
        drain();

        // Reset in the middle of a join discards pending and the error flag
        join_issue_valid = 1; join_issue_wid = 3;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        expect_state("mid_reset_w3", 2'd3, 4'h0, B, 4'h0, 1'b0);
        expect_state("mid_reset_w1", 2'd1, 4'h0, B, 4'h0, 1'b0);
        drain();

        // Orphan response right after reset: flagged, update still applied
        join_valid = 1; join_wid = 3; join_is_dvg = 1; join_is_else = 1;
        join_tmask = 4'hA; join_pc = 32'h80000200;
        tick();
        expect_state("orphan", 2'd3, 4'hA, 32'h80000200, 4'h0, 1'b1);
        drain();
        tick(); tick();
        expect_state("sticky_err", 2'd3, 4'hA, 32'h80000200, 4'h0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
